// File: rtl/axis_pl_stream_router.sv
// Header-parsing router for the 256-bit PL stream.
// Steers payload words to one of NUM_DEST AXIS consumers.
module axis_pl_stream_router #(
  parameter int          NUM_DEST = 4,
  parameter logic [7:0]  MAGIC    = 8'hA5
) (
  input  logic                pl_clk,
  input  logic                rst,
  input  logic [255:0]        s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [255:0]        m_axis_tdata,
  output logic [NUM_DEST-1:0] m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic [NUM_DEST-1:0] m_axis_tready,
  output logic                busy,
  output logic [7:0]          cur_dest,
  output logic [15:0]         bad_dest_cnt,
  output logic [15:0]         sync_err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DISCARD
  } state_t;

  localparam logic [8:0] ND = 9'(NUM_DEST);

  state_t state, state_nx;

  logic [15:0] remaining, remaining_nx;
  logic [15:0] bad_nx, sync_nx;
  logic [7:0]  dest_nx;

  logic [NUM_DEST-1:0] sel_valid;
  logic                sel_ready;

  logic        magic_ok;
  logic [15:0] hdr_len;
  logic [7:0]  hdr_dest;
  logic        dest_bad;
  logic        last_word;

  assign magic_ok  = (s_axis_tdata[255:248] == MAGIC);
  assign hdr_len   = s_axis_tdata[31:16];
  assign hdr_dest  = s_axis_tdata[7:0];
  assign dest_bad  = ({1'b0, hdr_dest} >= ND);
  assign last_word = (remaining == 16'd1);
  assign busy      = (state != IDLE);

  // One-hot select of the latched destination's valid/ready lanes
  always_comb begin
    sel_valid = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (cur_dest == 8'(i)) begin
        sel_valid[i] = 1'b1;
        sel_ready    = m_axis_tready[i];
      end
    end
  end

  // Next-state, counter updates and stream outputs
  always_comb begin
    state_nx      = state;
    remaining_nx  = remaining;
    dest_nx       = cur_dest;
    bad_nx        = bad_dest_cnt;
    sync_nx       = sync_err_cnt;
    s_axis_tready = 1'b0;
    m_axis_tvalid = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            if (!magic_ok) begin
              if (sync_err_cnt != 16'hFFFF)
                sync_nx = sync_err_cnt + 16'd1;
            end else if (dest_bad) begin
              if (bad_dest_cnt != 16'hFFFF)
                bad_nx = bad_dest_cnt + 16'd1;
              if (hdr_len != 16'd0) begin
                remaining_nx = hdr_len;
                state_nx     = DISCARD;
              end
            end else begin
              dest_nx = hdr_dest;
              if (hdr_len != 16'd0) begin
                remaining_nx = hdr_len;
                state_nx     = ROUTE;
              end
            end
          end
        end
        ROUTE: begin
          m_axis_tdata  = s_axis_tdata;
          m_axis_tvalid = sel_valid & {NUM_DEST{s_axis_tvalid}};
          m_axis_tlast  = last_word;
          s_axis_tready = sel_ready;
          if (s_axis_tvalid && sel_ready) begin
            remaining_nx = remaining - 16'd1;
            if (last_word)
              state_nx = IDLE;
          end
        end
        DISCARD: begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            remaining_nx = remaining - 16'd1;
            if (last_word)
              state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      cur_dest     <= '0;
      bad_dest_cnt <= '0;
      sync_err_cnt <= '0;
    end else begin
      state        <= state_nx;
      remaining    <= remaining_nx;
      cur_dest     <= dest_nx;
      bad_dest_cnt <= bad_nx;
      sync_err_cnt <= sync_nx;
    end
  end

endmodule
